// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an asynchronous PWM input against a nominal frame and reports the
// high time of each accepted frame as an 11-bit duty word. A frame runs from
// one rising edge to the next. A frame is accepted when its period lies within
// PERIOD +/- TOL. If no rising edge arrives within TIMEOUT clocks, the input
// is declared stuck.
//
// Parameters:
//   PERIOD   nominal clocks between rising edges
//   TOL      allowed +/- period deviation (inclusive)
//   TIMEOUT  clocks without a rising edge before stuck is declared (<= 4095)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   pwm_in    asynchronous PWM input
//   duty      last accepted high time in clocks, saturated to 0x7FF
//   duty_vld  one-clock pulse when duty is updated by a valid frame
//   per_err   one-clock pulse when a frame's period is out of tolerance
//   stuck     level; set on timeout, cleared by the next valid frame
//   synch     one-clock pulse on every detected rising edge
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int PERIOD  = 2048,
  parameter int TOL     = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [10:0] duty,
  output logic        duty_vld,
  output logic        per_err,
  output logic        stuck,
  output logic        synch
);

  localparam logic [11:0] CNT_MAX   = 12'hFFF;
  localparam logic [11:0] PER_LO    = 12'(PERIOD - TOL);
  localparam logic [11:0] PER_HI    = 12'(PERIOD + TOL);
  localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [11:0] r_per_cnt;
  logic [11:0] r_high_cnt;
  logic [10:0] r_duty;
  logic        r_duty_vld;
  logic        r_per_err;
  logic        r_stuck;
  logic        r_synch;

  logic        w_rise;
  logic        w_fall;
  logic        w_per_ok;
  logic        w_timeout;
  logic [10:0] w_high_sat;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  // Evaluated against the counter values from before the reload on rise.
  assign w_per_ok  = (r_per_cnt >= PER_LO) && (r_per_cnt <= PER_HI);
  assign w_timeout = (r_per_cnt == TIMEOUT_C);

  // NOTE: every signal assigned in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_high_sat = 11'h7FF;
    if (r_high_cnt[11] == 1'b0) w_high_sat = r_high_cnt[10:0];
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
      r_duty     <= '0;
      r_duty_vld <= 1'b0;
      r_per_err  <= 1'b0;
      r_stuck    <= 1'b0;
      r_synch    <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      // Counters saturate rather than wrap, so a dead input cannot alias
      // back into the valid period window.
      if (w_rise)                     r_per_cnt <= 12'd1;
      else if (r_per_cnt != CNT_MAX)  r_per_cnt <= r_per_cnt + 12'd1;

      if (w_rise)                             r_high_cnt <= 12'd1;
      else if (r_s2 && r_high_cnt != CNT_MAX) r_high_cnt <= r_high_cnt + 12'd1;

      r_duty_vld <= 1'b0;
      r_per_err  <= 1'b0;
      r_synch    <= w_rise;

      case (r_state)
        IDLE: begin
          // First edge after reset or timeout only opens a frame.
          if (w_rise) r_state <= HIGH;
        end
        HIGH, LOW: begin
          if (w_rise) begin
            // A rise takes priority over a coincident timeout.
            r_state <= HIGH;
            if (w_per_ok) begin
              r_duty     <= w_high_sat;
              r_duty_vld <= 1'b1;
              r_stuck    <= 1'b0;
            end else begin
              r_per_err <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_stuck <= 1'b1;
            r_duty  <= r_s2 ? 11'h7FF : 11'h000;
          end else if (r_state == HIGH && w_fall) begin
            r_state <= LOW;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign duty     = r_duty;
  assign duty_vld = r_duty_vld;
  assign per_err  = r_per_err;
  assign stuck    = r_stuck;
  assign synch    = r_synch;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed bench for pwm_capture. The PWM input changes only on falling clock
// edges, so every frame has an exact period and high time in clocks. Pulse
// outputs are tallied by a monitor sampling 1 ns after each rising edge; the
// tallies clear while reset is asserted.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  logic        clk;
  logic        rst_n;
  logic        pwm_in;
  logic [10:0] duty;
  logic        duty_vld;
  logic        per_err;
  logic        stuck;
  logic        synch;

  int n_vec;
  int n_err;
  int vld_cnt;
  int err_cnt;
  int synch_cnt;

  pwm_capture dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .duty     (duty),
    .duty_vld (duty_vld),
    .per_err  (per_err),
    .stuck    (stuck),
    .synch    (synch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      vld_cnt   = 0;
      err_cnt   = 0;
      synch_cnt = 0;
    end else begin
      if (duty_vld) vld_cnt++;
      if (per_err)  err_cnt++;
      if (synch)    synch_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hold pwm_in at a level for n clock periods; starts and ends on a negedge.
  task automatic drive(input logic level, input int n);
    pwm_in = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int high, input int period);
    drive(1'b1, high);
    drive(1'b0, period - high);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    vld_cnt   = 0;
    err_cnt   = 0;
    synch_cnt = 0;
    pwm_in    = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty",     32'(duty),     32'h000);
    check("rst_duty_vld", 32'(duty_vld), 32'h0);
    check("rst_per_err",  32'(per_err),  32'h0);
    check("rst_stuck",    32'(stuck),    32'h0);
    check("rst_synch",    32'(synch),    32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal frames 2048/1024: the first rise only opens a frame.
    frame(1024, 2048);
    check("f1_vld_cnt",   32'(vld_cnt),   32'd0);
    check("f1_synch_cnt", 32'(synch_cnt), 32'd1);
    frame(1024, 2048);
    check("f2_vld_cnt",   32'(vld_cnt),   32'd1);
    check("f2_duty",      32'(duty),      32'h400);
    frame(1024, 2048);
    check("f3_vld_cnt",   32'(vld_cnt),   32'd2);
    check("f3_duty",      32'(duty),      32'h400);
    check("f3_err_cnt",   32'(err_cnt),   32'd0);
    check("f3_synch_cnt", 32'(synch_cnt), 32'd3);

    // Period tolerance boundaries with high time 100.
    frame(100, 2056);
    check("f4_vld_cnt", 32'(vld_cnt), 32'd3);
    frame(100, 2040);
    check("per2056_vld_cnt", 32'(vld_cnt), 32'd4);
    check("per2056_duty",    32'(duty),    32'h064);
    frame(100, 2057);
    check("per2040_vld_cnt", 32'(vld_cnt), 32'd5);
    check("per2040_duty",    32'(duty),    32'h064);
    frame(100, 2039);
    check("per2057_err_cnt", 32'(err_cnt), 32'd1);
    check("per2057_vld_cnt", 32'(vld_cnt), 32'd5);
    check("per2057_duty",    32'(duty),    32'h064);

    // Stuck high: the rise that closes the 2039 frame, then 5000 clocks high.
    drive(1'b1, 3);
    check("per2039_synch",   32'(synch),   32'h1);
    check("per2039_per_err", 32'(per_err), 32'h1);
    drive(1'b1, 4094);
    check("hi_pre_to_stuck", 32'(stuck), 32'h0);
    check("hi_pre_to_duty",  32'(duty),  32'h064);
    drive(1'b1, 1);
    check("hi_to_stuck",    32'(stuck),    32'h1);
    check("hi_to_duty",     32'(duty),     32'h7FF);
    check("hi_to_duty_vld", 32'(duty_vld), 32'h0);
    drive(1'b1, 902);
    check("hi_hold_stuck",   32'(stuck),   32'h1);
    check("hi_hold_duty",    32'(duty),    32'h7FF);
    check("hi_hold_err_cnt", 32'(err_cnt), 32'd2);
    check("hi_hold_vld_cnt", 32'(vld_cnt), 32'd5);
    drive(1'b0, 1000);

    // Resume 2048/512: first rise reopens, second rise clears stuck.
    frame(512, 2048);
    check("res1_vld_cnt", 32'(vld_cnt), 32'd5);
    check("res1_stuck",   32'(stuck),   32'h1);
    frame(512, 2048);
    check("res2_vld_cnt", 32'(vld_cnt), 32'd6);
    check("res2_duty",    32'(duty),    32'h200);
    check("res2_stuck",   32'(stuck),   32'h0);

    // Stuck low: last rise was at the start of the previous frame.
    drive(1'b0, 2049);
    check("lo_pre_to_stuck", 32'(stuck), 32'h0);
    drive(1'b0, 1);
    check("lo_to_stuck", 32'(stuck), 32'h1);
    check("lo_to_duty",  32'(duty),  32'h000);
    drive(1'b0, 100);

    // High time 2048 in a 2050 frame saturates to 0x7FF.
    frame(2048, 2050);
    check("sat1_vld_cnt", 32'(vld_cnt), 32'd6);
    frame(2048, 2050);
    check("sat_vld_cnt", 32'(vld_cnt), 32'd7);
    check("sat_duty",    32'(duty),    32'h7FF);
    check("sat_stuck",   32'(stuck),   32'h0);

    // Reset 700 clocks into a frame.
    drive(1'b1, 300);
    drive(1'b0, 400);
    rst_n = 1'b0;
    #1;
    check("mid_rst_duty",     32'(duty),     32'h000);
    check("mid_rst_duty_vld", 32'(duty_vld), 32'h0);
    check("mid_rst_per_err",  32'(per_err),  32'h0);
    check("mid_rst_stuck",    32'(stuck),    32'h0);
    check("mid_rst_synch",    32'(synch),    32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    drive(1'b1, 3);
    check("post_rst1_synch",    32'(synch),    32'h1);
    check("post_rst1_duty_vld", 32'(duty_vld), 32'h0);
    check("post_rst1_per_err",  32'(per_err),  32'h0);
    drive(1'b1, 297);
    drive(1'b0, 1748);
    check("post_rst1_vld_cnt",   32'(vld_cnt),   32'd0);
    check("post_rst1_synch_cnt", 32'(synch_cnt), 32'd1);
    drive(1'b1, 3);
    check("post_rst2_duty_vld", 32'(duty_vld), 32'h1);
    check("post_rst2_duty",     32'(duty),     32'h12C);
    drive(1'b1, 297);
    drive(1'b0, 1748);
    check("post_rst2_vld_cnt", 32'(vld_cnt), 32'd1);
    check("post_rst2_err_cnt", 32'(err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
